// File: rtl/regfile_pkg.sv
// Shared defaults and port-count limits for the multi-port register file with scoreboard.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_NUM_RD = 2;
  localparam int unsigned RF_NUM_WR = 2;
  localparam int unsigned RF_MAX_RD = 4;
  localparam int unsigned RF_MAX_WR = 2;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// Per-register pending (busy) bits with alloc/writeback/flush priority and a registered popcount.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned NUM_WR     = RF_NUM_WR,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic                         flush,
  output logic [(2**ADDR_WIDTH)-1:0]   busy,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DEPTH-1:0] busy_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             alloc_ok;

  // Writeback clears, a new producer re-sets, flush wipes everything.
  always_comb begin
    busy_nxt = busy;
    alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));
    for (int i = 0; i < int'(NUM_WR); i++) begin
      if (wen[i]) busy_nxt[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
    end
    if (alloc_ok) busy_nxt[alloc_addr] = 1'b1;
    if (flush) busy_nxt = '0;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with optional zero register, write-to-read bypass and issue scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_W,
  parameter int unsigned DATA_WIDTH = RF_DATA_W,
  parameter int unsigned NUM_RD     = RF_NUM_RD,
  parameter int unsigned NUM_WR     = RF_NUM_WR,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_WR-1:0]            wen,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rbusy,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic                         flush,
  output logic [ADDR_WIDTH:0]          busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
    $error("regfile_mp_sb: NUM_RD out of range");
  end
  if (NUM_WR < 1 || NUM_WR > RF_MAX_WR) begin : g_bad_num_wr
    $error("regfile_mp_sb: NUM_WR out of range");
  end

  logic [DATA_WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0]      busy;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .flush      (flush),
    .busy       (busy),
    .busy_cnt   (busy_cnt)
  );

  // Later write ports are applied last so the highest index wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) rf[k] <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_WR); i++) begin
        if (wen[i] && !((ZERO_REG != 0) && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0))) begin
          rf[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Zero-latency read; a same-cycle write also hides the pending bit it is about to clear.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < int'(NUM_RD); j++) begin
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] val;
      logic                  bsy;
      ra  = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
      val = rf[ra];
      bsy = busy[ra];
      if (BYPASS != 0) begin
        for (int i = 0; i < int'(NUM_WR); i++) begin
          if (wen[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
            val = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            bsy = 1'b0;
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        val = '0;
        bsy = 1'b0;
      end
      rdata[j*DATA_WIDTH +: DATA_WIDTH] = val;
      rbusy[j] = bsy;
    end
  end

endmodule : regfile_mp_sb

// File: tb/tb_regfile_mp_sb.sv
// Randomized and directed check of regfile_mp_sb (bypass and non-bypass builds) against an array model.
module tb_regfile_mp_sb;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*AW-1:0] raddr;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic             flush;

  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rbusy_b, rbusy_n;
  logic [AW:0]      cnt_b, cnt_n;

  int n_chk = 0;
  int n_bad = 0;

  logic [DW-1:0] m_rf [DEPTH];
  bit   [DEPTH-1:0] m_busy;
  int   m_cnt;

  always #5 clk = ~clk;

  regfile_mp_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .busy_cnt(cnt_b)
  );

  regfile_mp_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .rbusy(rbusy_n), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .flush(flush), .busy_cnt(cnt_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input bit byp, input int ra);
    logic [DW-1:0] v;
    if (ra == 0) return '0;
    v = m_rf[ra];
    if (byp) begin
      for (int i = 0; i < NW; i++)
        if (wen[i] && int'(waddr[i*AW +: AW]) == ra) v = wdata[i*DW +: DW];
    end
    return v;
  endfunction

  function automatic bit exp_busy(input bit byp, input int ra);
    if (ra == 0) return 1'b0;
    if (byp) begin
      for (int i = 0; i < NW; i++)
        if (wen[i] && int'(waddr[i*AW +: AW]) == ra) return 1'b0;
    end
    return m_busy[ra];
  endfunction

  task automatic model_edge();
    bit [DEPTH-1:0] nb;
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) m_rf[k] = '0;
      m_busy = '0;
    end else begin
      nb = m_busy;
      for (int i = 0; i < NW; i++) begin
        if (wen[i]) begin
          int a;
          a = int'(waddr[i*AW +: AW]);
          if (a != 0) m_rf[a] = wdata[i*DW +: DW];
          nb[a] = 1'b0;
        end
      end
      if (alloc_en) nb[alloc_addr] = 1'b1;
      if (flush) nb = '0;
      nb[0] = 1'b0;
      m_busy = nb;
    end
    m_cnt = $countones(m_busy);
  endtask

  task automatic idle();
    rst = 0; wen = '0; waddr = '0; wdata = '0; raddr = '0;
    alloc_en = 0; alloc_addr = '0; flush = 0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  // Compare current combinational/registered outputs, then advance one edge.
  task automatic cycle();
    #2;
    for (int j = 0; j < NR; j++) begin
      int ra;
      ra = int'(raddr[j*AW +: AW]);
      check($sformatf("rdata_byp[%0d] r%0d", j, ra), 64'(rdata_b[j*DW +: DW]), 64'(exp_rd(1, ra)));
      check($sformatf("rdata_nbyp[%0d] r%0d", j, ra), 64'(rdata_n[j*DW +: DW]), 64'(exp_rd(0, ra)));
      check($sformatf("rbusy_byp[%0d] r%0d", j, ra), 64'(rbusy_b[j]), 64'(exp_busy(1, ra)));
      check($sformatf("rbusy_nbyp[%0d] r%0d", j, ra), 64'(rbusy_n[j]), 64'(exp_busy(0, ra)));
    end
    check("busy_cnt_byp", 64'(cnt_b), 64'(m_cnt));
    check("busy_cnt_nbyp", 64'(cnt_n), 64'(m_cnt));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) m_rf[k] = '0;
    m_busy = '0;
    m_cnt = 0;
    idle();
    set_rd(0, 9); set_rd(1, 31);
    cycle();

    // Same-cycle write and read of index 3, then re-read next cycle.
    idle(); set_wr(0, 3, 32'hDEADBEEF); set_rd(0, 3); set_rd(1, 3);
    cycle();
    idle(); set_rd(0, 3);
    cycle();

    // Both ports hit index 7; port 1 must win.
    idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7);
    cycle();
    idle(); set_rd(0, 7); set_rd(1, 7);
    cycle();
    check("rf7_collision", 64'(rdata_n[0 +: DW]), 64'h22);

    // Index 0 ignores write and alloc.
    idle(); set_wr(0, 0, 32'h55); alloc_en = 1; alloc_addr = '0;
    cycle();
    idle(); set_rd(0, 0); set_rd(1, 0);
    cycle();

    // Alloc, alloc+write collision, then writeback clears.
    idle(); alloc_en = 1; alloc_addr = 5;
    cycle();
    idle(); set_rd(0, 5); set_rd(1, 5);
    cycle();
    idle(); alloc_en = 1; alloc_addr = 5; set_wr(1, 5, 32'hA5A5); set_rd(0, 5);
    cycle();
    idle(); set_rd(0, 5);
    cycle();
    idle(); set_wr(0, 5, 32'h5A5A); set_rd(0, 5);
    cycle();
    idle(); set_rd(0, 5); set_rd(1, 5);
    cycle();

    // Three allocs, then flush alongside a fourth.
    for (int r = 1; r <= 3; r++) begin
      idle(); alloc_en = 1; alloc_addr = AW'(r); set_rd(0, r); set_rd(1, r - 1);
      cycle();
    end
    idle(); flush = 1; alloc_en = 1; alloc_addr = 4; set_rd(0, 2);
    cycle();
    for (int r = 1; r <= 4; r += 2) begin
      idle(); set_rd(0, r); set_rd(1, r + 1);
      cycle();
    end

    // Fill 1..31 with index value, then reset with writes active.
    for (int r = 1; r < DEPTH; r += 2) begin
      idle(); set_wr(0, r, DW'(r));
      if (r + 1 < DEPTH) set_wr(1, r + 1, DW'(r + 1));
      alloc_en = 1; alloc_addr = AW'(r);
      set_rd(0, r - 1); set_rd(1, r);
      cycle();
    end
    idle(); set_rd(0, 30); set_rd(1, 31);
    cycle();
    idle(); rst = 1; set_wr(0, 9, 32'hFFFF); set_wr(1, 10, 32'hEEEE);
    alloc_en = 1; alloc_addr = 11;
    cycle();
    for (int r = 0; r < DEPTH; r += 2) begin
      idle(); set_rd(0, r); set_rd(1, r + 1);
      cycle();
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(0, 2) != 0) set_wr(i, int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
      end
      for (int j = 0; j < NR; j++) set_rd(j, int'($urandom_range(0, DEPTH - 1)));
      alloc_en   = ($urandom_range(0, 1) == 1);
      alloc_addr = AW'($urandom_range(0, DEPTH - 1));
      flush      = ($urandom_range(0, 40) == 0);
      rst        = ($urandom_range(0, 150) == 0);
      if ($urandom_range(0, 5) == 0 && wen[0]) set_rd(0, int'(waddr[0 +: AW]));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_regfile_mp_sb

// File: doc/regfile_mp_sb.md
REGFILE_MP_SB -- requirements
Module: regfile_mp_sb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports (1..2).
REQ-005 SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads zero and is never written or busy.
REQ-006 SHALL have parameter BYPASS, default 1; when 1, same-cycle writes forward to reads.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-008 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port wen, input, NUM_WR, per-port write enable.
REQ-010 SHALL have port waddr, input, NUM_WR*ADDR_WIDTH, packed write indices; port i at slice i.
REQ-011 SHALL have port wdata, input, NUM_WR*DATA_WIDTH, packed write data.
REQ-012 SHALL have port raddr, input, NUM_RD*ADDR_WIDTH, packed read indices.
REQ-013 SHALL have port rdata, output, NUM_RD*DATA_WIDTH, packed read data.
REQ-014 SHALL have port rbusy, output, NUM_RD, per read port: operand has a pending producer.
REQ-015 SHALL have port alloc_en, input, 1, mark alloc_addr pending (instruction issued).
REQ-016 SHALL have port alloc_addr, input, ADDR_WIDTH, register being allocated.
REQ-017 SHALL have port flush, input, 1, clear all pending bits.
REQ-018 SHALL have port busy_cnt, output, ADDR_WIDTH+1, registered count of pending registers.

Function
REQ-019 SHALL write wdata slice i to rf[waddr i] at the edge when wen[i]=1 and rst=0; writes to index 0 dropped when ZERO_REG=1.
REQ-020 SHALL resolve two write ports to the same index in one cycle: higher port index wins.
REQ-021 SHALL drive rdata combinationally (zero latency); index 0 returns 0 when ZERO_REG=1.
REQ-022 SHALL, when BYPASS=1, return the same-cycle wdata of the highest-index write port matching raddr with wen set; when BYPASS=0, return the stored value (new value visible next cycle).
REQ-023 SHALL keep one busy bit per register: alloc_en sets busy[alloc_addr] at the edge; any wen[i] clears busy[waddr i].
REQ-024 SHALL, on simultaneous alloc and write to the same index, leave busy set (new producer wins); the data write still happens.
REQ-025 SHALL give flush priority over alloc and writeback: all busy bits zero next edge; register data writes still occur.
REQ-026 SHALL drive rbusy[j] = busy[raddr j], masked to 0 when BYPASS=1 and a same-cycle write hits raddr j, and 0 for index 0 when ZERO_REG=1.
REQ-027 SHALL update busy_cnt each edge to the population count of the next busy vector; never exceeds 2**ADDR_WIDTH.
REQ-028 SHALL ignore alloc_en to index 0 when ZERO_REG=1.

Reset
REQ-029 SHALL, while rst=1 at an edge, clear every register to 0, every busy bit to 0 and busy_cnt to 0; rst dominates wen, alloc_en, flush.
REQ-030 SHALL, after rst deasserts mid-operation, read 0 from all registers with rbusy=0 until new writes/allocs.

Structure
REQ-031 SHALL place default widths and port-count limits as constants in shared package regfile_pkg.
REQ-032 SHALL implement the busy vector, set/clear priority and popcount in sub-module regfile_scoreboard; data array stays in the top.

Verification
REQ-033 SHALL test: wen[0]=1 waddr0=3 wdata0=0xDEADBEEF, raddr0=3 same cycle -> rdata0=0xDEADBEEF (BYPASS=1), 0 then 0xDEADBEEF next cycle (BYPASS=0).
REQ-034 SHALL test: both ports write index 7 with 0x11 and 0x22 -> rf[7]=0x22.
REQ-035 SHALL test: write 0x55 to index 0 and alloc index 0 -> rdata=0, rbusy=0, busy_cnt=0.
REQ-036 SHALL test: alloc 5, next cycle rbusy=1 busy_cnt=1; alloc 5 and write 5 same cycle -> busy stays 1; write 5 alone -> rbusy=0, busy_cnt=0.
REQ-037 SHALL test: alloc 1,2,3 over three cycles then flush with alloc 4 -> busy_cnt=0, all rbusy=0.
REQ-038 SHALL test: fill registers 1..31 with index value, assert rst one cycle with wen active -> all reads 0, busy_cnt=0.
